// File: rtl/board_controller.sv
// rtl/board_controller.sv - block-breaker board state: hit arbitration, destroyed mask, score and game FSM
module board_controller #(
  parameter int NBLOCKS           = 16,
  parameter int SCORE_W           = 8,
  parameter int CLEAR_HOLD_FRAMES = 120
) (
  input  logic               pclk,
  input  logic               reset,
  input  logic               vblnk_in,
  input  logic               start,
  input  logic               hit_valid_a,
  input  logic [3:0]         hit_idx_a,
  output logic               hit_ready_a,
  input  logic               hit_valid_b,
  input  logic [3:0]         hit_idx_b,
  output logic               hit_ready_b,
  output logic [NBLOCKS-1:0] blocks_out,
  output logic [SCORE_W-1:0] score,
  output logic [4:0]         blocks_left,
  output logic               board_cleared,
  output logic [1:0]         state_out
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PLAY    = 2'd1;
  localparam logic [1:0] S_CLEARED = 2'd2;
  localparam logic [1:0] S_REFILL  = 2'd3;
  localparam int CNT_W = $clog2(CLEAR_HOLD_FRAMES + 1);

  logic [1:0]         state;
  logic [NBLOCKS-1:0] mask;
  logic [CNT_W-1:0]   frames;
  logic               rr_b;      // 0: A wins the next contention, 1: B wins
  logic               vblnk_d;
  logic               frame_tick;
  logic               in_play;
  logic               accept;
  logic [3:0]         acc_idx;
  logic               is_new;
  logic               hold_done;

  assign frame_tick = vblnk_in & ~vblnk_d;
  assign in_play    = ~reset & (state == S_PLAY);

  // Readies look only at valids, state and the round-robin pointer, never at the index.
  assign hit_ready_a = in_play & hit_valid_a & (~hit_valid_b | ~rr_b);
  assign hit_ready_b = in_play & hit_valid_b & (~hit_valid_a | rr_b);
  assign accept      = hit_ready_a | hit_ready_b;
  assign acc_idx     = hit_ready_a ? hit_idx_a : hit_idx_b;
  // Duplicates are consumed but change nothing.
  assign is_new      = accept & ~mask[acc_idx];
  assign hold_done   = (state == S_CLEARED) && (frames == CNT_W'(CLEAR_HOLD_FRAMES));

  assign board_cleared = (state == S_CLEARED);
  assign state_out     = state;

  // Frame edge detection and tear-free publication of the mask to the renderer.
  always_ff @(posedge pclk) begin
    if (reset) begin
      vblnk_d    <= 1'b0;
      blocks_out <= '0;
    end else begin
      vblnk_d <= vblnk_in;
      if (frame_tick) blocks_out <= mask;
    end
  end

  // Round-robin pointer flips only when both sources contend in PLAY.
  always_ff @(posedge pclk) begin
    if (reset) rr_b <= 1'b0;
    else if (in_play && hit_valid_a && hit_valid_b) rr_b <= ~rr_b;
  end

  // Internal mask, blocks_left and saturating score; refill wipes the board.
  always_ff @(posedge pclk) begin
    if (reset) begin
      mask        <= '0;
      blocks_left <= 5'(NBLOCKS);
      score       <= '0;
    end else if (hold_done) begin
      mask        <= '0;
      blocks_left <= 5'(NBLOCKS);
    end else if (is_new) begin
      mask[acc_idx] <= 1'b1;
      blocks_left   <= blocks_left - 5'd1;
      if (score != '1) score <= score + 1'b1;
    end
  end

  // Game sequencing: IDLE -> PLAY -> CLEARED (hold frames) -> REFILL -> PLAY.
  always_ff @(posedge pclk) begin
    if (reset) begin
      state  <= S_IDLE;
      frames <= '0;
    end else begin
      case (state)
        S_IDLE:    if (start) state <= S_PLAY;
        S_PLAY:    if (is_new && blocks_left == 5'd1) state <= S_CLEARED;
        S_CLEARED: begin
          if (hold_done) begin
            state  <= S_REFILL;
            frames <= '0;
          end else if (frame_tick) begin
            frames <= frames + 1'b1;
          end
        end
        S_REFILL:  if (frame_tick) state <= S_PLAY;
        default:   state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_controller.sv
// tb/tb_board_controller.sv - randomized bench for board_controller with a set-based reference model
module tb_board_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vblnk = 1'b0;
  logic        start = 1'b0;
  logic        va = 1'b0, vb = 1'b0;
  logic [3:0]  ia = '0, ib = '0;
  logic        ready_a, ready_b;
  logic [15:0] blocks_out;
  logic [7:0]  score;
  logic [4:0]  blocks_left;
  logic        board_cleared;
  logic [1:0]  state_out;

  board_controller dut (
    .pclk(clk), .reset(reset), .vblnk_in(vblnk), .start(start),
    .hit_valid_a(va), .hit_idx_a(ia), .hit_ready_a(ready_a),
    .hit_valid_b(vb), .hit_idx_b(ib), .hit_ready_b(ready_b),
    .blocks_out(blocks_out), .score(score), .blocks_left(blocks_left),
    .board_cleared(board_cleared), .state_out(state_out)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  bit seen_ra = 1'b0, seen_rb = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the board is a set of destroyed blocks; phases are named by plain ints.
  bit          dead[16];
  int          m_phase;   // 0 idle, 1 play, 2 cleared, 3 refill
  int          m_score;
  int          m_ticks;
  bit          m_prefer_b;
  bit          m_vprev;
  logic [15:0] m_pub;

  function automatic int n_dead();
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(dead[i]);
    return n;
  endfunction

  function automatic logic [15:0] dead_word();
    logic [15:0] w = '0;
    for (int i = 0; i < 16; i++) w[i] = dead[i];
    return w;
  endfunction

  // Which source is served: -1 none, 0 A, 1 B.
  function automatic int winner(input bit rst, input int ph, input bit a, input bit b, input bit pb);
    if (rst || ph != 1) return -1;
    if (a && b) return pb ? 1 : 0;
    if (a) return 0;
    if (b) return 1;
    return -1;
  endfunction

  int          w_m;
  bit          tick_m;
  logic [15:0] before_m;
  int          idx_m;

  always @(posedge clk) begin
    before_m = dead_word();
    tick_m   = vblnk && !m_vprev;
    w_m      = winner(reset, m_phase, va, vb, m_prefer_b);
    if (reset) begin
      for (int i = 0; i < 16; i++) dead[i] = 1'b0;
      m_phase = 0; m_score = 0; m_ticks = 0; m_prefer_b = 1'b0; m_vprev = 1'b0; m_pub = '0;
    end else begin
      m_vprev = vblnk;
      if (tick_m) m_pub = before_m;
      if (m_phase == 1 && va && vb) m_prefer_b = !m_prefer_b;
      case (m_phase)
        0: if (start) m_phase = 1;
        1: if (w_m >= 0) begin
          idx_m = (w_m == 0) ? int'(ia) : int'(ib);
          if (!dead[idx_m]) begin
            dead[idx_m] = 1'b1;
            m_score = (m_score < 255) ? m_score + 1 : 255;
            if (n_dead() == 16) m_phase = 2;
          end
        end
        2: if (m_ticks == 120) begin
          m_phase = 3; m_ticks = 0;
          for (int i = 0; i < 16; i++) dead[i] = 1'b0;
        end else if (tick_m) m_ticks++;
        default: if (tick_m) m_phase = 1;
      endcase
    end
  end

  // Every-cycle comparison, mid-cycle away from the active edge.
  int w_c;
  always @(negedge clk) begin
    seen_ra = ready_a;
    seen_rb = ready_b;
    if (chk_en) begin
      w_c = winner(reset, m_phase, va, vb, m_prefer_b);
      chk("ready_a", 32'(ready_a), 32'(w_c == 0));
      chk("ready_b", 32'(ready_b), 32'(w_c == 1));
      chk("blocks_out", 32'(blocks_out), 32'(m_pub));
      chk("score", 32'(score), 32'(m_score));
      chk("blocks_left", 32'(blocks_left), 32'(16 - n_dead()));
      chk("state", 32'(state_out), 32'(m_phase));
      chk("board_cleared", 32'(board_cleared), 32'(m_phase == 2));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_vbl();
    vblnk = 1'b1; step();
    vblnk = 1'b0; step();
  endtask

  int vcnt;

  initial begin
    step(); chk_en = 1'b1;
    step(); step();
    reset = 1'b0; #1;
    chk("rst_left", 32'(blocks_left), 32'd16);
    chk("rst_state", 32'(state_out), 32'd0);
    chk("rst_out", 32'(blocks_out), 32'd0);
    chk("rst_score", 32'(score), 32'd0);

    // Start and a single hit
    start = 1'b1; step(); start = 1'b0;
    chk("play", 32'(state_out), 32'd1);
    va = 1'b1; ia = 4'd3; #1;
    chk("t1_ready", 32'(ready_a), 32'd1);
    step(); va = 1'b0;
    chk("t1_left", 32'(blocks_left), 32'd15);
    chk("t1_score", 32'(score), 32'd1);
    chk("t1_out_hold", 32'(blocks_out), 32'd0);
    pulse_vbl();
    chk("t1_out", 32'(blocks_out), 32'h0008);

    // Contention for two cycles: A then B
    va = 1'b1; ia = 4'd5; vb = 1'b1; ib = 4'd9; #1;
    chk("t2_a_first", 32'({ready_a, ready_b}), 32'b10);
    step(); #1;
    chk("t2_b_second", 32'({ready_a, ready_b}), 32'b01);
    step(); va = 1'b0; vb = 1'b0;
    pulse_vbl();
    chk("t2_out", 32'(blocks_out), 32'h0228);

    // Duplicates
    va = 1'b1; ia = 4'd7; step(); step(); va = 1'b0;
    chk("t3_dup_score", 32'(score), 32'd4);
    va = 1'b1; ia = 4'd2; vb = 1'b1; ib = 4'd2; #1;
    chk("t3_rr_back_a", 32'({ready_a, ready_b}), 32'b10);
    step(); step(); va = 1'b0; vb = 1'b0;
    chk("t3_score", 32'(score), 32'd5);
    chk("t3_left", 32'(blocks_left), 32'd11);

    // Clear the board
    for (int i = 0; i < 16; i++) begin
      va = 1'b1; ia = 4'(i); step();
    end
    va = 1'b1; ia = 4'd4; #1;
    chk("t4_cleared_state", 32'(state_out), 32'd2);
    chk("t4_cleared_flag", 32'(board_cleared), 32'd1);
    chk("t5_ready_cleared", 32'(ready_a), 32'd0);
    start = 1'b1; step(); start = 1'b0;
    chk("t5_start_ignored", 32'(state_out), 32'd2);
    for (int f = 0; f < 120; f++) pulse_vbl();
    chk("t4_refill", 32'(state_out), 32'd3);
    vblnk = 1'b1; step();
    chk("t4_replay", 32'(state_out), 32'd1);
    chk("t4_out0", 32'(blocks_out), 32'd0);
    chk("t4_left16", 32'(blocks_left), 32'd16);
    chk("t4_score16", 32'(score), 32'd16);
    chk("t5_held_ready", 32'(ready_a), 32'd1);
    vblnk = 1'b0; step(); va = 1'b0;

    // Reset mid-play with a published 0x00FF mask
    for (int i = 0; i < 8; i++) begin
      va = 1'b1; ia = 4'(i); step();
    end
    va = 1'b0;
    pulse_vbl();
    chk("t6_out_ff", 32'(blocks_out), 32'h00FF);
    va = 1'b1; ia = 4'd0; reset = 1'b1; step();
    chk("t6_out", 32'(blocks_out), 32'd0);
    chk("t6_score", 32'(score), 32'd0);
    chk("t6_state", 32'(state_out), 32'd0);
    chk("t6_ready", 32'(ready_a), 32'd0);
    reset = 1'b0; step();
    chk("t5_ready_idle", 32'(ready_a), 32'd0);
    start = 1'b1; step(); start = 1'b0; #1;
    chk("t5_held_first_play", 32'(ready_a), 32'd1);
    step(); va = 1'b0;

    // Randomized phase with the valid/hold protocol
    vcnt = 0;
    for (int c = 0; c < 6000; c++) begin
      if (!va || seen_ra) begin va = ($urandom_range(0, 2) != 0); ia = 4'($urandom); end
      if (!vb || seen_rb) begin vb = ($urandom_range(0, 2) != 0); ib = 4'($urandom); end
      vcnt++;
      vblnk = ((vcnt % 12) >= 9);
      start = ($urandom_range(0, 49) == 0);
      reset = ($urandom_range(0, 2999) == 0);
      step();
    end
    reset = 1'b0; start = 1'b0; va = 1'b0; vb = 1'b0;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
